// File: rtl/pc_gen_unit.sv
// pc_gen_unit: program counter generator with BOOT/RUN/HALT control, a one-entry stall redirect buffer and trap override.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned redirect targets into traps and pulses misalign.
module pc_gen_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(64'h100),
    parameter int unsigned     INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_req,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] PC_Out,
    output logic            pc_valid,
    output logic            redirect_pending,
    output logic            misalign
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] redir_tgt;

    // A fresh branch always beats the buffered one.
    assign redir_tgt = branch_taken ? branch_target : pend_tgt_q;

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    logic redir_bad;
    assign redir_bad = (redir_tgt & XLEN'(INSTR_BYTES - 1)) != '0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
        mis_d      = 1'b0;
`endif
        if (trap_req) begin
            state_d = ST_RUN;
            pc_d    = TRAP_VEC;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (halt_req || !PCWrite) begin
                        if (branch_taken) begin
                            pend_d     = 1'b1;
                            pend_tgt_d = branch_target;
                        end
                        if (halt_req) state_d = ST_HALT;
                    end else if (branch_taken || pend_q) begin
                        pend_d = 1'b0;
                        pc_d   = redir_tgt;
`ifdef PC_ALIGN_CHECK_EN
                        if (redir_bad) begin
                            pc_d  = TRAP_VEC;
                            mis_d = 1'b1;
                        end
`endif
                    end else begin
                        pc_d = pc_q + XLEN'(INSTR_BYTES);
                    end
                end
                ST_HALT: begin
                    if (branch_taken) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = branch_target;
                    end
                    if (!halt_req && resume) state_d = ST_RUN;
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign PC_Out           = pc_q;
    assign pc_valid         = (state_q == ST_RUN);
    assign redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus randomized traffic against a behavioural model.
// Honours PC_ALIGN_CHECK_EN the same way the design does.
module tb_pc_gen_unit;

    localparam logic [63:0] TRAP = 64'h100;
    localparam logic [63:0] RVEC = 64'h0;
    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCWrite = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        trap_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [63:0] PC_Out;
    logic        pc_valid;
    logic        redirect_pending;
    logic        misalign;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: booting / halted flags rather than a state code.
    logic [63:0] m_pc, m_ptgt;
    bit          m_pend, m_mis, m_booting, m_halted;

    pc_gen_unit #(.XLEN(64), .RESET_VEC(RVEC), .TRAP_VEC(TRAP), .INSTR_BYTES(STEP)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .branch_taken(branch_taken),
        .branch_target(branch_target), .trap_req(trap_req), .halt_req(halt_req),
        .resume(resume), .PC_Out(PC_Out), .pc_valid(pc_valid),
        .redirect_pending(redirect_pending), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RVEC; m_pend = 0; m_ptgt = '0; m_mis = 0; m_booting = 1; m_halted = 0;
    endtask

    task automatic model_edge(input bit pw, input bit bt, input logic [63:0] tgt,
                              input bit tr, input bit hr, input bit rs);
        logic [63:0] t;
        m_mis = 0;
        if (tr) begin
            m_pc = TRAP; m_pend = 0; m_booting = 0; m_halted = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (m_halted) begin
            if (bt) begin m_pend = 1; m_ptgt = tgt; end
            if (!hr && rs) m_halted = 0;
        end else if (hr || !pw) begin
            if (bt) begin m_pend = 1; m_ptgt = tgt; end
            if (hr) m_halted = 1;
        end else if (bt || m_pend) begin
            t = bt ? tgt : m_ptgt;
            m_pend = 0;
            m_pc = t;
`ifdef PC_ALIGN_CHECK_EN
            if (t % STEP != 0) begin m_pc = TRAP; m_mis = 1; end
`endif
        end else begin
            m_pc = m_pc + STEP;
        end
    endtask

    task automatic compare_all();
        check("pc", PC_Out, m_pc);
        check("pc_valid", {63'd0, pc_valid}, {63'd0, !m_booting && !m_halted});
        check("pending", {63'd0, redirect_pending}, {63'd0, m_pend});
        check("misalign", {63'd0, misalign}, {63'd0, m_mis});
    endtask

    // Called just after a rising edge; drives, advances one edge, then checks.
    task automatic cycle(input bit pw, input bit bt, input logic [63:0] tgt,
                         input bit tr, input bit hr, input bit rs);
        PCWrite = pw; branch_taken = bt; branch_target = tgt;
        trap_req = tr; halt_req = hr; resume = rs;
        @(posedge clk);
        model_edge(pw, bt, tgt, tr, hr, rs);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_async_pc", PC_Out, RVEC);
        check("rst_async_valid", {63'd0, pc_valid}, 64'd0);
        check("rst_async_pend", {63'd0, redirect_pending}, 64'd0);
        check("rst_async_mis", {63'd0, misalign}, 64'd0);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        PCWrite = 1'b1; branch_taken = 0; trap_req = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        #1;
        do_reset();

        // Boot then sequential fetch
        cycle(1, 0, '0, 0, 0, 0);
        check("boot_pc", PC_Out, 64'h0);
        check("boot_valid", {63'd0, pc_valid}, 64'd1);
        cycle(1, 0, '0, 0, 0, 0);
        check("seq_pc4", PC_Out, 64'h4);
        cycle(1, 0, '0, 0, 0, 0);
        check("seq_pc8", PC_Out, 64'h8);

        // Stall with buffered branch, release later
        cycle(1, 1, 64'h20, 0, 0, 0);
        check("br_0x20", PC_Out, 64'h20);
        cycle(0, 1, 64'h80, 0, 0, 0);
        check("stall_hold", PC_Out, 64'h20);
        check("stall_pend", {63'd0, redirect_pending}, 64'd1);
        cycle(0, 0, '0, 0, 0, 0);
        check("stall_hold2", PC_Out, 64'h20);
        cycle(1, 0, '0, 0, 0, 0);
        check("release_pc", PC_Out, 64'h80);
        check("release_pend", {63'd0, redirect_pending}, 64'd0);

        // Last buffered wins, but a coincident new branch beats it
        cycle(0, 1, 64'h40, 0, 0, 0);
        cycle(0, 1, 64'h60, 0, 0, 0);
        cycle(1, 1, 64'h90, 0, 0, 0);
        check("newbr_pc", PC_Out, 64'h90);
        check("newbr_pend", {63'd0, redirect_pending}, 64'd0);

        // Halt, branch captured during halt, resume, then redirect
        cycle(1, 1, 64'h10, 0, 0, 0);
        cycle(1, 0, '0, 0, 1, 0);
        check("halt_pc", PC_Out, 64'h10);
        check("halt_valid", {63'd0, pc_valid}, 64'd0);
        cycle(1, 1, 64'h200, 0, 0, 0);
        check("halt_hold", PC_Out, 64'h10);
        cycle(1, 0, '0, 0, 1, 1);
        check("halt_prio", {63'd0, pc_valid}, 64'd0);
        cycle(1, 0, '0, 0, 0, 1);
        check("resume_pc", PC_Out, 64'h10);
        check("resume_valid", {63'd0, pc_valid}, 64'd1);
        cycle(1, 0, '0, 0, 0, 0);
        check("after_resume", PC_Out, 64'h200);

        // Wrap and trap under stall
        cycle(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        cycle(1, 0, '0, 0, 0, 0);
        check("wrap_pc", PC_Out, 64'h0);
        cycle(0, 0, '0, 1, 0, 0);
        check("trap_pc", PC_Out, TRAP);

        // Misaligned target
        cycle(1, 1, 64'h102, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc", PC_Out, TRAP);
        check("mis_pulse", {63'd0, misalign}, 64'd1);
`else
        check("mis_pc", PC_Out, 64'h102);
        check("mis_pulse", {63'd0, misalign}, 64'd0);
`endif
        cycle(1, 0, '0, 0, 0, 0);
        check("mis_clear", {63'd0, misalign}, 64'd0);

        // Reset during stall drops the pending entry
        cycle(0, 1, 64'h300, 0, 0, 0);
        do_reset();
        check("rst_drop_pend", {63'd0, redirect_pending}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [63:0] t;
            t = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) t = t | 64'h2;
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, t,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
